// File: rtl/enigma_pkg.sv
// Shared constants, types and position helpers for the Enigma rotor sequencer.
package enigma_pkg;

  localparam int unsigned LETTERS  = 26;
  localparam int unsigned NOTCH1   = 17;
  localparam int unsigned NOTCH2   = 5;
  localparam int unsigned PIPE_LAT = 7;

  typedef logic [6:0] letter_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_LOAD
  } ctrl_state_e;

  function automatic letter_t next_pos(letter_t p, int unsigned letters = LETTERS);
    return (p == letter_t'(letters)) ? letter_t'(1) : p + letter_t'(1);
  endfunction

  // Positions are 1-based; anything outside 1..letters falls back to 1.
  function automatic letter_t clamp_pos(letter_t p, int unsigned letters = LETTERS);
    return ((p == '0) || (p > letter_t'(letters))) ? letter_t'(1) : p;
  endfunction

endpackage

// File: rtl/enigma_pos_delay.sv
// Fixed-depth shift line of rotor positions; every tap resets to position 1.
module enigma_pos_delay
  import enigma_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [6:0]           pos_i,
  output logic [DEPTH:1][6:0]  taps_o
);

  logic [DEPTH:1][6:0] r_taps;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        r_taps[k] <= letter_t'(1);
      end
    end else begin
      r_taps[1] <= pos_i;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        r_taps[k] <= r_taps[k-1];
      end
    end
  end

  assign taps_o = r_taps;

endmodule

// File: rtl/enigma_rotor_ctrl.sv
// Rotor sequencer: accepts letters, steps rotors with double-step, and drains
// the encoding pipeline before any run-time position change.
module enigma_rotor_ctrl #(
  parameter int unsigned LETTERS  = enigma_pkg::LETTERS,
  parameter int unsigned NOTCH1   = enigma_pkg::NOTCH1,
  parameter int unsigned NOTCH2   = enigma_pkg::NOTCH2,
  parameter int unsigned PIPE_LAT = enigma_pkg::PIPE_LAT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rotors_rst_i,
  input  logic            cfg_load_i,
  input  logic [6:0]      cfg_r1_i,
  input  logic [6:0]      cfg_r2_i,
  input  logic [6:0]      cfg_r3_i,
  input  logic [6:0]      sym_i,
  input  logic            sym_val_i,
  output logic            sym_rdy_o,
  output logic [6:0]      in_symb_o,
  output logic            en_val_o,
  output logic [6:0]      r1_o,
  output logic [5:1][6:0] r1_d_o,
  output logic [6:0]      r2_o,
  output logic [4:1][6:0] r2_d_o,
  output logic [6:0]      r3_o,
  output logic [3:1][6:0] r3_d_o,
  output logic            busy_o
);

  import enigma_pkg::*;

  ctrl_state_e       r_state, w_state_nxt;
  letter_t           r_r1, r_r2, r_r3;
  letter_t           r_st1, r_st2, r_st3;
  letter_t           r_symb;
  logic              r_en_val;
  logic [PIPE_LAT:0] r_track;

  logic w_rdy, w_xfer, w_req, w_drained;
  logic w_r1_notch, w_r2_notch;

  assign w_xfer     = sym_val_i & w_rdy;
  assign w_req      = cfg_load_i | rotors_rst_i;
  // A letter accepted on the request edge is not in the tracker yet.
  assign w_drained  = (r_track == '0) & ~r_en_val;
  assign w_r1_notch = (r_r1 == letter_t'(NOTCH1));
  assign w_r2_notch = (r_r2 == letter_t'(NOTCH2));

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN: begin
        w_rdy = 1'b1;
        if (w_req) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_drained) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_r1     <= letter_t'(1);
      r_r2     <= letter_t'(1);
      r_r3     <= letter_t'(1);
      r_st1    <= letter_t'(1);
      r_st2    <= letter_t'(1);
      r_st3    <= letter_t'(1);
      r_symb   <= '0;
      r_en_val <= 1'b0;
      r_track  <= '0;
    end else begin
      r_en_val <= w_xfer;
      r_track  <= {r_track[PIPE_LAT-1:0], r_en_val};
      if (w_xfer) r_symb <= sym_i;

      // Start positions are captured at request time; a plain rotor reset keeps them.
      if ((r_state == S_RUN) && cfg_load_i) begin
        r_st1 <= clamp_pos(cfg_r1_i, LETTERS);
        r_st2 <= clamp_pos(cfg_r2_i, LETTERS);
        r_st3 <= clamp_pos(cfg_r3_i, LETTERS);
      end

      if (w_xfer) begin
        r_r1 <= next_pos(r_r1, LETTERS);
        if (w_r1_notch || w_r2_notch) r_r2 <= next_pos(r_r2, LETTERS);
        if (w_r2_notch)               r_r3 <= next_pos(r_r3, LETTERS);
      end else if ((r_state == S_DRAIN) && w_drained) begin
        r_r1 <= r_st1;
        r_r2 <= r_st2;
        r_r3 <= r_st3;
      end
    end
  end

  enigma_pos_delay #(.DEPTH(5)) u_r1_dly (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pos_i  (r_r1),
    .taps_o (r1_d_o)
  );

  enigma_pos_delay #(.DEPTH(4)) u_r2_dly (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pos_i  (r_r2),
    .taps_o (r2_d_o)
  );

  enigma_pos_delay #(.DEPTH(3)) u_r3_dly (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pos_i  (r_r3),
    .taps_o (r3_d_o)
  );

  assign sym_rdy_o = w_rdy;
  assign in_symb_o = r_symb;
  assign en_val_o  = r_en_val;
  assign r1_o      = r_r1;
  assign r2_o      = r_r2;
  assign r3_o      = r_r3;
  assign busy_o    = (|r_track) | (r_state != S_RUN);

endmodule
